// File: rtl/fir_line_filter_pkg.sv
// Shared types and constants for the FIR line filter datapath.
package fir_line_filter_pkg;

  localparam int FIR_LANES     = 16;
  localparam int FIR_COEF_FRAC = 15;
  localparam int FIR_PROD_W    = 48;

  typedef logic [511:0]       t_block;
  typedef logic signed [31:0] t_fir_sample;
  typedef logic signed [15:0] t_fir_coef;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } t_fir_state;

endpackage

// File: rtl/fir_line_filter_if.sv
// Line stream bundle: input lines from the read engine, filtered lines to the write engine.
interface fir_line_filter_if;
  import fir_line_filter_pkg::*;

  logic   in_valid;
  logic   in_ready;
  t_block in_data;
  logic   out_valid;
  logic   out_ready;
  t_block out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fir_tap_lane.sv
// One output lane: P2 product registers, adder tree, >>>15 and 32-bit reduction into P3.
// FIR_SATURATE_EN selects clamping; otherwise the low 32 bits wrap.
module fir_tap_lane
  import fir_line_filter_pkg::*;
#(
  parameter int NUM_TAPS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load2,
  input  logic                     load3,
  input  logic [NUM_TAPS*32-1:0]   taps,
  input  logic [NUM_TAPS*16-1:0]   coefs,
  output t_fir_sample              result
);

  localparam int ACC_W = FIR_PROD_W + $clog2(NUM_TAPS);
  localparam int SHR_W = ACC_W - FIR_COEF_FRAC;

  logic signed [FIR_PROD_W-1:0] prod_reg [NUM_TAPS];
  logic signed [ACC_W-1:0]      acc;
  logic signed [SHR_W-1:0]      shifted;
  t_fir_sample                  reduced;
  t_fir_sample                  result_reg;

  // taps[k] holds x[n-k] for this lane
  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
    t_fir_sample                  tap_s;
    t_fir_coef                    coef_s;
    logic signed [FIR_PROD_W-1:0] prod;

    assign tap_s  = taps[gi*32 +: 32];
    assign coef_s = coefs[gi*16 +: 16];
    assign prod   = FIR_PROD_W'(tap_s) * FIR_PROD_W'(coef_s);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        prod_reg[gi] <= '0;
      end else if (load2) begin
        prod_reg[gi] <= prod;
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc = acc + ACC_W'(prod_reg[k]);
    end
    shifted = SHR_W'(acc >>> FIR_COEF_FRAC);
`ifdef FIR_SATURATE_EN
    if (shifted > SHR_W'(32'sh7FFF_FFFF)) begin
      reduced = 32'sh7FFF_FFFF;
    end else if (shifted < SHR_W'(32'sh8000_0000)) begin
      reduced = 32'sh8000_0000;
    end else begin
      reduced = shifted[31:0];
    end
`else
    reduced = shifted[31:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_reg <= '0;
    end else if (load3) begin
      result_reg <= reduced;
    end
  end

  assign result = result_reg;

endmodule

// File: rtl/fir_line_filter.sv
// Streaming NUM_TAPS-tap FIR over 512-bit lines with job FSM, cross-line history and P1 window.
// Optional build macro: FIR_SATURATE_EN (clamp results instead of wrapping).
module fir_line_filter
  import fir_line_filter_pkg::*;
#(
  parameter int NUM_TAPS = 4,
  parameter int LANES    = FIR_LANES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        num_lines,
  input  logic               coef_wr,
  input  logic [3:0]         coef_idx,
  input  logic [15:0]        coef_data,
  fir_line_filter_if.slave   stream,
  output logic               busy,
  output logic               done
);

  localparam int HIST = NUM_TAPS - 1;
  localparam int WIN  = LANES + HIST;

  t_fir_state  state_reg;
  logic [31:0] num_lines_reg;
  logic [31:0] in_lines_reg;
  logic [31:0] out_lines_reg;

  t_fir_coef   coef_reg [NUM_TAPS];
  t_fir_sample hist_reg [HIST];
  t_fir_sample win_reg  [WIN];
  t_fir_sample lane_out [LANES];

  logic [NUM_TAPS*16-1:0] coef_flat;

  logic p1_valid_reg;
  logic p2_valid_reg;
  logic out_valid_reg;

  logic stall;
  logic en2;
  logic en3;
  logic load2;
  logic load3;
  logic in_ready;
  logic in_fire;
  logic out_fire;

  // Each stage advances whenever its downstream slot is empty or draining
  assign stall    = out_valid_reg && !stream.out_ready;
  assign en3      = !stall;
  assign en2      = !p2_valid_reg || en3;
  assign load2    = p1_valid_reg && en2;
  assign load3    = p2_valid_reg && en3;
  assign in_ready = (state_reg == S_RUN) && !stall && (in_lines_reg < num_lines_reg);
  assign in_fire  = stream.in_valid && in_ready;
  assign out_fire = out_valid_reg && stream.out_ready;

  assign stream.in_ready  = in_ready;
  assign stream.out_valid = out_valid_reg;
  assign busy             = (state_reg != S_IDLE);
  assign done             = (state_reg == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      num_lines_reg <= '0;
      in_lines_reg  <= '0;
      out_lines_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            num_lines_reg <= num_lines;
            in_lines_reg  <= '0;
            out_lines_reg <= '0;
            state_reg     <= (num_lines == 32'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (in_fire) begin
            in_lines_reg <= in_lines_reg + 32'd1;
          end
          if (out_fire) begin
            out_lines_reg <= out_lines_reg + 32'd1;
            if (out_lines_reg + 32'd1 == num_lines_reg) begin
              state_reg <= S_DONE;
            end
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_valid_reg  <= 1'b0;
      p2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (in_fire) begin
        p1_valid_reg <= 1'b1;
      end else if (load2) begin
        p1_valid_reg <= 1'b0;
      end
      if (load2) begin
        p2_valid_reg <= 1'b1;
      end else if (load3) begin
        p2_valid_reg <= 1'b0;
      end
      if (load3) begin
        out_valid_reg <= 1'b1;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Window is oldest first: history tail, then lanes 0..LANES-1 of the new line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < HIST; j++) hist_reg[j] <= '0;
      for (int j = 0; j < WIN; j++)  win_reg[j]  <= '0;
    end else if (state_reg == S_IDLE && start) begin
      for (int j = 0; j < HIST; j++) hist_reg[j] <= '0;
    end else if (in_fire) begin
      for (int j = 0; j < HIST; j++) begin
        win_reg[j]  <= hist_reg[j];
        hist_reg[j] <= stream.in_data[(LANES-HIST+j)*32 +: 32];
      end
      for (int j = 0; j < LANES; j++) begin
        win_reg[HIST+j] <= stream.in_data[j*32 +: 32];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_coef
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        coef_reg[gi] <= '0;
      end else if (coef_wr && state_reg == S_IDLE && coef_idx == 4'(gi)) begin
        coef_reg[gi] <= coef_data;
      end
    end
    assign coef_flat[gi*16 +: 16] = coef_reg[gi];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [NUM_TAPS*32-1:0] taps_flat;

    for (genvar gk = 0; gk < NUM_TAPS; gk++) begin : g_win
      assign taps_flat[gk*32 +: 32] = win_reg[HIST+gi-gk];
    end

    fir_tap_lane #(
      .NUM_TAPS (NUM_TAPS)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load2  (load2),
      .load3  (load3),
      .taps   (taps_flat),
      .coefs  (coef_flat),
      .result (lane_out[gi])
    );
  end

  always_comb begin
    stream.out_data = '0;
    for (int j = 0; j < LANES; j++) begin
      stream.out_data[j*32 +: 32] = lane_out[j];
    end
  end

endmodule

// File: tb/tb_fir_line_filter.sv
// Directed self-checking bench for fir_line_filter (NUM_TAPS = 4); expectations are hand-derived.
module tb_fir_line_filter;
  import fir_line_filter_pkg::*;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] num_lines = '0;
  logic        coef_wr = 1'b0;
  logic [3:0]  coef_idx = '0;
  logic [15:0] coef_data = '0;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  t_block lines_in  [8];
  t_block lines_exp [8];

  fir_line_filter_if bus ();

  fir_line_filter #(
    .NUM_TAPS (NT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_lines (num_lines),
    .coef_wr   (coef_wr),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .stream    (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input t_block obs, input t_block exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic t_block splat(input logic [31:0] v);
    t_block b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = v;
    return b;
  endfunction

  task automatic write_coef(input logic [3:0] idx, input logic [15:0] val);
    @(posedge clk); #1;
    coef_wr = 1'b1; coef_idx = idx; coef_data = val;
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  task automatic set_coefs(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [15:0] c3);
    write_coef(4'd0, c0);
    write_coef(4'd1, c1);
    write_coef(4'd2, c2);
    write_coef(4'd3, c3);
  endtask

  task automatic start_job(input int n);
    @(posedge clk); #1;
    start = 1'b1; num_lines = 32'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_lines(input int n);
    for (int l = 0; l < n; l++) begin
      int   waited;
      logic ok;
      waited = 0; ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = lines_in[l];
      while (!ok && waited < 200) begin
        @(negedge clk);
        ok = bus.in_ready;
        waited++;
      end
      if (!ok) begin
        check("in_accept", 512'(ok), 512'(1));
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect_lines(input int n, input int s_at, input int s_len);
    int     got, cyc;
    t_block held;
    logic   held_v;
    got = 0; cyc = 0; held = '0; held_v = 1'b0;
    while (got < n && cyc < 100 + s_len) begin
      bus.out_ready = !(cyc >= s_at && cyc < s_at + s_len);
      @(negedge clk);
      if (held_v) check("hold_data", bus.out_data, held);
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("line%0d", got), bus.out_data, lines_exp[got]);
        got++;
        held_v = 1'b0;
      end else if (bus.out_valid) begin
        check("stall_in_ready", 512'(bus.in_ready), 512'(0));
        held   = bus.out_data;
        held_v = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("out_count", 512'(got), 512'(n));
    bus.out_ready = 1'b1;
  endtask

  task automatic run_job(input int n, input int s_at, input int s_len, input bit poke);
    int d0;
    d0 = done_cnt;
    start_job(n);
    @(negedge clk);
    check("busy_run", 512'(busy), 512'(1));
    @(posedge clk); #1;
    if (poke) write_coef(4'd0, 16'h7FFF);
    fork
      drive_lines(n);
      collect_lines(n, s_at, s_len);
    join
    repeat (3) @(negedge clk);
    check("done_pulse", 512'(done_cnt - d0), 512'(1));
    check("idle_busy", 512'(busy), 512'(0));
    check("idle_out_valid", 512'(bus.out_valid), 512'(0));
  endtask

  initial begin
    int          n, d0;
    logic [31:0] sat_v1, sat_v2, sat_ss;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  512'(bus.in_ready),  512'(0));
    check("rst_out_valid", 512'(bus.out_valid), 512'(0));
    check("rst_out_data",  bus.out_data,        512'(0));
    check("rst_busy",      512'(busy),          512'(0));
    check("rst_done",      512'(done),          512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Identity: y = n*65536 - 2n for global sample index n
    set_coefs(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 16; i++) begin
        n = l * 16 + i;
        lines_in[l][i*32 +: 32]  = 32'(n * 65536);
        lines_exp[l][i*32 +: 32] = 32'(n * 65536 - 2 * n);
      end
    end
    run_job(2, 1000, 0, 1'b0);

    // Cross-line history: lane 0 of line 1 sees the zero tail of line 0
    set_coefs(16'h4000, 16'h4000, 16'h0000, 16'h0000);
    lines_in[0]  = '0;
    lines_in[1]  = splat(32'd1000);
    lines_exp[0] = '0;
    lines_exp[1] = splat(32'd1000);
    lines_exp[1][31:0] = 32'd500;
    run_job(2, 1000, 0, 1'b0);

    // Overflow: ramp-up lanes of line 0, then steady state 4*(2^31-1)*(2^15-1)>>>15
`ifdef FIR_SATURATE_EN
    sat_v1 = 32'h7FFF_FFFF; sat_v2 = 32'h7FFF_FFFF; sat_ss = 32'h7FFF_FFFF;
`else
    sat_v1 = 32'hFFFD_FFFE; sat_v2 = 32'h7FFC_FFFD; sat_ss = 32'hFFFB_FFFC;
`endif
    set_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    lines_in[0]  = splat(32'h7FFF_FFFF);
    lines_in[1]  = splat(32'h7FFF_FFFF);
    lines_exp[0] = splat(sat_ss);
    lines_exp[0][31:0]  = 32'h7FFE_FFFF;
    lines_exp[0][63:32] = sat_v1;
    lines_exp[0][95:64] = sat_v2;
    lines_exp[1] = splat(sat_ss);
    run_job(2, 1000, 0, 1'b0);

    // Backpressure: 10-cycle stall once the first output appears
    set_coefs(16'h4000, 16'h0000, 16'h0000, 16'h0000);
    for (int l = 0; l < 5; l++) begin
      lines_in[l]  = splat(32'((l + 1) * 1000));
      lines_exp[l] = splat(32'((l + 1) * 500));
    end
    run_job(5, 3, 10, 1'b0);

    // coef_wr during S_RUN is dropped; -1001*0.5 floors to -501
    lines_in[0]  = splat(32'hFFFF_FC17);
    lines_exp[0] = splat(32'hFFFF_FE0B);
    run_job(1, 1000, 0, 1'b1);

    // Zero-length job
    d0 = done_cnt;
    start_job(0);
    @(negedge clk);
    check("zero_done", 512'(done), 512'(1));
    check("zero_out_valid", 512'(bus.out_valid), 512'(0));
    @(negedge clk);
    check("zero_done_cleared", 512'(done), 512'(0));
    check("zero_done_count", 512'(done_cnt - d0), 512'(1));
    check("zero_busy", 512'(busy), 512'(0));

    // Reset after 2 of 4 lines
    set_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    lines_in[0] = splat(32'd5000);
    lines_in[1] = splat(32'd5000);
    bus.out_ready = 1'b1;
    start_job(4);
    drive_lines(2);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 512'(bus.out_valid), 512'(0));
    check("mid_rst_busy", 512'(busy), 512'(0));
    check("mid_rst_in_ready", 512'(bus.in_ready), 512'(0));
    repeat (6) @(negedge clk);
    check("mid_rst_no_done", 512'(done_cnt), 512'(d0));
    check("mid_rst_quiet", 512'(bus.out_valid), 512'(0));

    write_coef(4'd0, 16'h4000);
    lines_in[0]  = splat(32'd1000);
    lines_exp[0] = splat(32'd500);
    run_job(1, 1000, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
